// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divide unit: f3 encodings, functional-unit
// select values and the divider state encoding.
package div_unit_pkg;

    localparam logic [2:0] DIV_F3  = 3'b100;
    localparam logic [2:0] DIVU_F3 = 3'b101;
    localparam logic [2:0] REM_F3  = 3'b110;
    localparam logic [2:0] REMU_F3 = 3'b111;

    localparam logic [2:0] FU_ALU    = 3'd0;
    localparam logic [2:0] FU_MUL    = 3'd1;
    localparam logic [2:0] FU_DIV    = 3'd2;
    localparam logic [2:0] FU_LOAD   = 3'd3;
    localparam logic [2:0] FU_STORE  = 3'd4;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // f3[0]==0 selects the signed variants, f3[1] selects remainder.
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return !f3[0];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Register-read bundle, flush and writeback handshake seen by the divide unit.
// master = upstream/writeback side, slave = the divide unit.
interface div_unit_if #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3,
    parameter int PREG_W = 7
);
    logic                  RR_valid;
    logic [2:0]            RR_fu_sel;
    logic [2:0]            RR_f3;
    logic [XLEN-1:0]       RR_rs1_data;
    logic [XLEN-1:0]       RR_rs2_data;
    logic [PREG_W-1:0]     RR_rd;
    logic [ROB_W-1:0]      RR_rob_idx;
    logic                  EX_ready;

    logic                  mispredict;
    logic [2**ROB_W-1:0]   flush_mask;

    logic                  WB_valid;
    logic [XLEN-1:0]       WB_data;
    logic [PREG_W-1:0]     WB_rd;
    logic [ROB_W-1:0]      WB_rob_idx;
    logic                  WB_ready;

    modport master (
        output RR_valid, RR_fu_sel, RR_f3, RR_rs1_data, RR_rs2_data, RR_rd, RR_rob_idx,
        output mispredict, flush_mask, WB_ready,
        input  EX_ready, WB_valid, WB_data, WB_rd, WB_rob_idx
    );

    modport slave (
        input  RR_valid, RR_fu_sel, RR_f3, RR_rs1_data, RR_rs2_data, RR_rd, RR_rob_idx,
        input  mispredict, flush_mask, WB_ready,
        output EX_ready, WB_valid, WB_data, WB_rd, WB_rob_idx
    );
endinterface

// File: rtl/div_iter_core.sv
// Unsigned restoring divider datapath: a 2*XLEN remainder/quotient register and
// one shift-subtract step per enabled cycle. next_quot/next_rem expose the step result.
module div_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_quot,
    output logic [XLEN-1:0] next_rem
);
    // Upper half holds the partial remainder, lower half shifts dividend out / quotient in.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     trial_hi;
    logic [XLEN-1:0]   diff;

    always_comb begin
        // Partial remainder shifted left by one, pulling in the next dividend bit.
        trial_hi = acc_q[2*XLEN-1:XLEN-1];
        diff     = trial_hi[XLEN-1:0] - dvsr_q;
        if (trial_hi >= {1'b0, dvsr_q}) begin
            acc_next = {diff, acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {trial_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    assign next_quot = acc_next[XLEN-1:0];
    assign next_rem  = acc_next[2*XLEN-1:XLEN];

    // NOTE: datapath registers are reset too, so a fresh unit never exposes X on its outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            acc_q  <= {{XLEN{1'b0}}, dividend};
            dvsr_q <= divisor;
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit with flush and writeback handshake.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero, overflow and |a|<|b| finish in one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3,
    parameter int PREG_W = 7,
    parameter int FU_ID  = 2
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              rem_sel_q;
    logic [PREG_W-1:0] rd_q;
    logic [ROB_W-1:0]  rob_q;
    logic              quot_neg_q, rem_neg_q, div0_q, ovf_q;
    logic [XLEN-1:0]   dividend_q, result_q;

    logic              in_flush, own_flush, accept, final_step;
    logic              is_signed, a_neg, b_neg, in_div0, in_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   core_quot, core_rem, quot_fix, rem_fix, final_result;
    logic              take_fast;
    logic [XLEN-1:0]   fast_result;

    assign in_flush  = bus.mispredict && bus.flush_mask[bus.RR_rob_idx];
    assign own_flush = bus.mispredict && bus.flush_mask[rob_q];
    assign accept    = bus.RR_valid && (state_q == DIV_IDLE)
                       && (bus.RR_fu_sel == 3'(FU_ID)) && !in_flush;
    assign final_step = (state_q == DIV_BUSY) && (cnt_q == LAST_CNT);

    assign is_signed = f3_is_signed(bus.RR_f3);
    assign a_neg     = is_signed && bus.RR_rs1_data[XLEN-1];
    assign b_neg     = is_signed && bus.RR_rs2_data[XLEN-1];
    assign a_mag     = a_neg ? -bus.RR_rs1_data : bus.RR_rs1_data;
    assign b_mag     = b_neg ? -bus.RR_rs2_data : bus.RR_rs2_data;
    assign in_div0   = (bus.RR_rs2_data == '0);
    assign in_ovf    = is_signed && (bus.RR_rs1_data == INT_MIN) && (bus.RR_rs2_data == '1);

`ifdef DIV_FAST_SPECIAL_EN
    always_comb begin
        take_fast = in_div0 || in_ovf || (a_mag < b_mag);
        if (in_div0)     fast_result = f3_is_rem(bus.RR_f3) ? bus.RR_rs1_data : '1;
        else if (in_ovf) fast_result = f3_is_rem(bus.RR_f3) ? '0 : INT_MIN;
        else             fast_result = f3_is_rem(bus.RR_f3) ? bus.RR_rs1_data : '0;
    end
`else
    assign take_fast   = 1'b0;
    assign fast_result = '0;
`endif

    div_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == DIV_BUSY),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .next_quot (core_quot),
        .next_rem  (core_rem)
    );

    // Sign fixup plus RISC-V special cases, applied to the last iteration's output.
    always_comb begin
        quot_fix = quot_neg_q ? -core_quot : core_quot;
        rem_fix  = rem_neg_q  ? -core_rem  : core_rem;
        if (div0_q) begin
            quot_fix = '1;
            rem_fix  = dividend_q;
        end else if (ovf_q) begin
            quot_fix = INT_MIN;
            rem_fix  = '0;
        end
        final_result = rem_sel_q ? rem_fix : quot_fix;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (accept) state_d = take_fast ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (own_flush)       state_d = DIV_IDLE;
                else if (final_step) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (own_flush)         state_d = DIV_IDLE;
                else if (bus.WB_ready) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_sel_q  <= 1'b0;
            rd_q       <= '0;
            rob_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dividend_q <= '0;
            result_q   <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            rem_sel_q  <= f3_is_rem(bus.RR_f3);
            rd_q       <= bus.RR_rd;
            rob_q      <= bus.RR_rob_idx;
            quot_neg_q <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div0_q     <= in_div0;
            ovf_q      <= in_ovf;
            dividend_q <= bus.RR_rs1_data;
            if (take_fast) result_q <= fast_result;
        end else if (state_q == DIV_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (final_step) result_q <= final_result;
        end
    end

    assign bus.EX_ready   = (state_q == DIV_IDLE);
    assign bus.WB_valid   = (state_q == DIV_DONE) && !own_flush;
    assign bus.WB_data    = result_q;
    assign bus.WB_rd      = rd_q;
    assign bus.WB_rob_idx = rob_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush/stall/reset
// scenarios and randomized operations against a plain-arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int XLEN = 32, ROB_W = 3, PREG_W = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W)) bus ();

    div_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W), .FU_ID(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    // Cycles counted from the first sample after the accept edge until WB_valid shows.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        logic [31:0] ma, mb;
        bit fast, fast_mode;
        ma = (!f3[0] && a[31]) ? -a : a;
        mb = (!f3[0] && b[31]) ? -b : b;
        fast = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
`ifdef DIV_FAST_SPECIAL_EN
        fast_mode = 1'b1;
`else
        fast_mode = 1'b0;
`endif
        return (fast_mode && fast) ? 0 : 32;
    endfunction

    task automatic idle_inputs();
        bus.RR_valid = 0; bus.RR_fu_sel = FU_ALU; bus.RR_f3 = 0;
        bus.RR_rs1_data = 0; bus.RR_rs2_data = 0; bus.RR_rd = 0; bus.RR_rob_idx = 0;
        bus.mispredict = 0; bus.flush_mask = 0; bus.WB_ready = 1;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] rd, input logic [2:0] rob);
        bus.RR_valid = 1; bus.RR_fu_sel = FU_DIV; bus.RR_f3 = f3;
        bus.RR_rs1_data = a; bus.RR_rs2_data = b; bus.RR_rd = rd; bus.RR_rob_idx = rob;
        @(negedge clk);
        bus.RR_valid = 0;
    endtask

    task automatic wait_result(input string tag, input int lat, input logic [31:0] data,
                               input logic [6:0] rd, input logic [2:0] rob);
        int n = 0;
        while (!bus.WB_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_data"}, 64'(bus.WB_data), 64'(data));
        check({tag, "_rd"}, 64'(bus.WB_rd), 64'(rd));
        check({tag, "_rob"}, 64'(bus.WB_rob_idx), 64'(rob));
        if (bus.WB_valid && bus.WB_ready) begin
            @(negedge clk);
            check({tag, "_idle"}, 64'(bus.EX_ready), 64'd1);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
    } vec_t;

    vec_t dir[10] = '{
        '{DIV_F3,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD},
        '{REM_F3,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF},
        '{DIVU_F3, 32'd100,       32'd0,        32'hFFFF_FFFF},
        '{REMU_F3, 32'd100,       32'd0,        32'd100},
        '{DIV_F3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{REM_F3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{DIV_F3,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{REM_F3,  32'd7,         32'hFFFF_FFFE, 32'd1},
        '{DIVU_F3, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF},
        '{REM_F3,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9}
    };

    initial begin
        bit seen;
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_ex_ready", 64'(bus.EX_ready), 64'd1);
        check("rst_wb_valid", 64'(bus.WB_valid), 64'd0);
        rst = 0;
        @(negedge clk);
        check("rst_wb_data", 64'(bus.WB_data), 64'd0);
        check("rst_wb_rd", 64'(bus.WB_rd), 64'd0);
        check("rst_wb_rob", 64'(bus.WB_rob_idx), 64'd0);

        // Directed corner cases with hand-computed results.
        foreach (dir[i]) begin
            issue(dir[i].f3, dir[i].a, dir[i].b, 7'(i + 1), 3'd3);
            wait_result($sformatf("dir%0d", i), ref_latency(dir[i].f3, dir[i].a, dir[i].b),
                        dir[i].exp, 7'(i + 1), 3'd3);
        end

        // Flush of the in-flight op by its own ROB index: nothing is written back.
        issue(DIVU_F3, 32'd1000, 32'd7, 7'd11, 3'd5);
        repeat (9) @(negedge clk);
        bus.mispredict = 1; bus.flush_mask = 8'h20;
        check("flush_busy_ex_ready", 64'(bus.EX_ready), 64'd0);
        @(negedge clk);
        bus.mispredict = 0; bus.flush_mask = 0;
        check("flush_ex_ready", 64'(bus.EX_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.WB_valid) seen = 1;
        end
        check("flush_no_wb", 64'(seen), 64'd0);

        // Flush of some other ROB entry leaves the op alone.
        issue(DIV_F3, -32'd1000, 32'd7, 7'd12, 3'd5);
        repeat (9) @(negedge clk);
        bus.mispredict = 1; bus.flush_mask = 8'h01;
        @(negedge clk);
        bus.mispredict = 0; bus.flush_mask = 0;
        wait_result("flush_other", 22, 32'hFFFF_FF72, 7'd12, 3'd5);

        // Writeback stall: outputs hold while a competing bundle waits upstream.
        bus.WB_ready = 0;
        issue(DIVU_F3, 32'd1000, 32'd7, 7'd21, 3'd2);
        wait_result("stall", 32, 32'd142, 7'd21, 3'd2);
        bus.RR_valid = 1; bus.RR_fu_sel = FU_DIV; bus.RR_f3 = REMU_F3;
        bus.RR_rs1_data = 32'd50; bus.RR_rs2_data = 32'd8; bus.RR_rd = 7'd22; bus.RR_rob_idx = 3'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("stall_valid%0d", c), 64'(bus.WB_valid), 64'd1);
            check($sformatf("stall_data%0d", c), 64'(bus.WB_data), 64'd142);
            check($sformatf("stall_rd%0d", c), 64'(bus.WB_rd), 64'd21);
            check($sformatf("stall_ex_ready%0d", c), 64'(bus.EX_ready), 64'd0);
        end
        bus.WB_ready = 1;
        @(negedge clk);
        check("stall_release_valid", 64'(bus.WB_valid), 64'd0);
        check("stall_release_ready", 64'(bus.EX_ready), 64'd1);
        @(negedge clk);
        bus.RR_valid = 0;
        wait_result("second", 32, 32'd2, 7'd22, 3'd4);

        // Flush while parked in DONE kills the writeback immediately.
        bus.WB_ready = 0;
        issue(DIV_F3, 32'hFFFF_FFF9, 32'd2, 7'd30, 3'd6);
        wait_result("doneflush", 32, 32'hFFFF_FFFD, 7'd30, 3'd6);
        bus.mispredict = 1; bus.flush_mask = 8'h40;
        #1;
        check("doneflush_valid", 64'(bus.WB_valid), 64'd0);
        @(negedge clk);
        bus.mispredict = 0; bus.flush_mask = 0; bus.WB_ready = 1;
        check("doneflush_idle", 64'(bus.EX_ready), 64'd1);
        check("doneflush_novalid", 64'(bus.WB_valid), 64'd0);

        // Bundles for another unit, or flushed in the same cycle, are not taken.
        bus.RR_valid = 1; bus.RR_fu_sel = FU_MUL; bus.RR_f3 = DIVU_F3;
        bus.RR_rs1_data = 32'd10; bus.RR_rs2_data = 32'd3; bus.RR_rob_idx = 3'd1;
        @(negedge clk);
        check("fu1_ignored", 64'(bus.EX_ready), 64'd1);
        bus.RR_fu_sel = FU_DIV; bus.RR_rob_idx = 3'd6; bus.mispredict = 1; bus.flush_mask = 8'h40;
        @(negedge clk);
        idle_inputs();
        check("inflush_ignored", 64'(bus.EX_ready), 64'd1);
        seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.WB_valid) seen = 1;
        end
        check("ignored_no_wb", 64'(seen), 64'd0);

        // Reset mid-operation abandons it; the unit is usable right after.
        issue(DIV_F3, 32'd1000, 32'd7, 7'd40, 3'd1);
        repeat (10) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_wb_valid", 64'(bus.WB_valid), 64'd0);
        check("midrst_ex_ready", 64'(bus.EX_ready), 64'd1);
        rst = 0;
        issue(DIVU_F3, 32'd9, 32'd3, 7'd41, 3'd2);
        wait_result("after_rst", 32, 32'd3, 7'd41, 3'd2);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3;
            logic [31:0] a, b;
            logic [6:0] rd;
            logic [2:0] rob;
            f3 = {1'b1, 2'($urandom)};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: b = $urandom_range(0, 15);
                2: a = $urandom_range(0, 15);
                default: begin
                    if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
                    b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0;
                end
            endcase
            rd = 7'($urandom);
            rob = 3'($urandom);
            issue(f3, a, b, rd, rob);
            wait_result($sformatf("rnd%0d", i), ref_latency(f3, a, b), ref_result(f3, a, b), rd, rob);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divide/remainder functional unit in the EX stage; serves fu_sel 2 (div/rem).
- Consumes one register-read-stage output bundle per operation.
- Returns the result to the shared writeback path with a valid/ready handshake.
- Honours mispredict flushes by ROB index; one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width
- ROB_W, 3, ROB index width; flush_mask is 2**ROB_W bits
- PREG_W, 7, physical register index width
- FU_ID, 2, fu_sel value this unit accepts

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RR_valid  in  1  upstream bundle valid
- RR_fu_sel  in  3  functional-unit select of bundle
- RR_f3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- RR_rs1_data  in  XLEN  dividend
- RR_rs2_data  in  XLEN  divisor
- RR_rd  in  PREG_W  destination physical register
- RR_rob_idx  in  ROB_W  ROB index
- EX_ready  out  1  unit can accept; drives EX_ready[FU_ID] upstream
- mispredict  in  1  flush strobe
- flush_mask  in  2**ROB_W  ROB entries to kill
- WB_valid  out  1  result valid
- WB_data  out  XLEN  quotient or remainder
- WB_rd  out  PREG_W  destination register
- WB_rob_idx  out  ROB_W  ROB index of result
- WB_ready  in  1  writeback arbiter accepts

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state IDLE, counter 0, all datapath registers 0, WB_valid=0, EX_ready=1.
- EX_ready = (state==IDLE). Purely registered-state based, with no combinational path from RR_valid.
- Accept when RR_valid && EX_ready && RR_fu_sel==FU_ID && !(mispredict && flush_mask[RR_rob_idx]).
  - On accept, latch f3, rd, rob_idx, and operand signs (f3[0]==0 means signed).
  - Latch absolute-value operands; counter=0; go to BUSY.
- Flushed incoming bundle: dropped; state stays IDLE.
- BUSY: one restoring shift-subtract iteration per cycle on a 2*XLEN remainder register.
  - Counter increments; after iteration XLEN-1 (counter==31), go to DONE.
  - Sign-fixed result is registered on that same edge.
- Latency: accept on edge k gives WB_valid high in the cycle after edge k+32.
- Sign fixup:
  - Quotient is negated if signs differ (signed ops).
  - Remainder takes the dividend sign.
  - f3[1] selects remainder.
- Special results (RISC-V):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Without the optional feature, these are still produced after the full iteration count by override at the final edge.
- DONE: WB_valid = !(mispredict && flush_mask[WB_rob_idx]). WB_data, WB_rd and WB_rob_idx are held stable.
  - WB_valid && WB_ready: go to IDLE.
  - Otherwise hold DONE indefinitely.
- Flush: mispredict && flush_mask[latched rob_idx] in BUSY or DONE returns to IDLE on the next edge with no writeback. Flush has priority over WB_ready and over iteration completion.
- Rst during BUSY/DONE: abandons the operation; reset values next cycle.
- Back-to-back: the earliest next accept is the cycle after the WB handshake; there is no overlap.

Optional Feature:
- Macro DIV_FAST_SPECIAL_EN.
- Defined:
  - Divisor 0 or signed overflow goes IDLE→DONE at the accept edge, so WB_valid rises 1 cycle after accept.
  - Dividend unsigned-magnitude < divisor magnitude also completes in 1 cycle: quotient 0, remainder = dividend.
- Undefined: every operation takes 32 cycles; results are identical.

Decomposition:
- Shared package holds:
  - f3 encodings (DIV_F3, DIVU_F3, REM_F3, REMU_F3)
  - fu_sel constants (FU_ALU..FU_STORE)
  - div state enum
- One natural sub-module: div_iter_core (remainder/quotient registers plus single-step subtract). The top keeps the FSM, sign fixup, flush and handshake.

Test Plan:
- DIV -7/2 (0xFFFFFFF9, 2), rob 3, WB_ready=1 → WB_valid 32 cycles after accept, WB_data 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. Latency is 32, or 1 with DIV_FAST_SPECIAL_EN.
- Accept rob 5, assert mispredict with flush_mask=0x20 at cycle 10 → no WB_valid ever; EX_ready high the next cycle. flush_mask=0x01 instead → result still written back.
- Hold WB_ready=0 for 20 cycles in DONE → WB_valid, data, rd stable; EX_ready=0; a second RR_valid with fu_sel 2 is not accepted until after the handshake.
- RR_valid with fu_sel 1 → ignored; RR_valid fu_sel 2 with a same-cycle matching flush → not accepted.
- Assert rst mid-BUSY → WB_valid=0, EX_ready=1 the next cycle; a fresh DIVU 9/3 then returns 3.
